// File: rtl/imem_boot_loader_pkg.sv
// Shared types and helpers for the instruction-memory boot loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HOLD,
    RUN,
    ERR
  } loader_state_t;

  localparam bit ORDER_BIG    = 1'b1;
  localparam bit ORDER_LITTLE = 1'b0;

  // Widest word byte_lane can slice; narrower words are zero-extended by the caller.
  localparam int XLEN_MAX = 64;

  function automatic logic [7:0] byte_lane(input logic [XLEN_MAX-1:0] word,
                                           input int                  lane,
                                           input bit                  big_endian,
                                           input int                  nbytes);
    int                  idx;
    logic [XLEN_MAX-1:0] sh;
    idx = big_endian ? (nbytes - 1 - lane) : lane;
    sh  = word >> (8 * idx);
    return sh[7:0];
  endfunction

endpackage

// File: rtl/imem_boot_loader_if.sv
// Valid/ready word stream from the host/debug source into the boot loader.
interface imem_boot_loader_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [XLEN-1:0] in_data;
  logic            in_ready;

  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/imem_boot_loader_word_serializer.sv
// Holds one word and emits it as BYTES consecutive byte writes starting at a base address.
module word_serializer
  import imem_loader_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 10,
  parameter bit BIG_ENDIAN = ORDER_BIG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [XLEN-1:0]   word,
  input  logic [ADDR_W-1:0] base,
  output logic              empty,
  output logic              last_byte,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata
);

  localparam int BYTES  = XLEN / 8;
  localparam int LANE_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [XLEN-1:0]   word_q;
  logic [LANE_W-1:0] lane_q;

  assign empty     = !mem_we;
  assign last_byte = mem_we && (lane_q == LANE_W'(BYTES - 1));

  // NOTE: non-blocking assignments keep every register update on the same edge,
  // independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_q    <= '0;
      lane_q    <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (load) begin
      // A new word may land on the last byte of the previous one: no bubble.
      word_q    <= word;
      lane_q    <= '0;
      mem_we    <= 1'b1;
      mem_addr  <= base;
      mem_wdata <= byte_lane(XLEN_MAX'(word), 0, BIG_ENDIAN, BYTES);
    end else if (mem_we) begin
      if (last_byte) begin
        mem_we <= 1'b0;
      end else begin
        lane_q    <= lane_q + LANE_W'(1);
        mem_addr  <= mem_addr + ADDR_W'(1);
        mem_wdata <= byte_lane(XLEN_MAX'(word_q), int'(lane_q) + 1, BIG_ENDIAN, BYTES);
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams words into the byte-wide instruction RAM, then releases core reset
// after a guard interval.
module imem_boot_loader
  import imem_loader_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_WORDS = 256,
  parameter  bit BIG_ENDIAN  = ORDER_BIG,
  parameter  int RESET_HOLD  = 2,
  localparam int BYTES       = XLEN / 8,
  localparam int CNT_W       = $clog2(DEPTH_WORDS + 1),
  localparam int ADDR_W      = $clog2(DEPTH_WORDS * BYTES)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [CNT_W-1:0]     num_words,
  imem_boot_loader_if.slave    stream,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [7:0]           mem_wdata,
  output logic                 core_reset,
  output logic                 done,
  output logic                 error,
  output logic [CNT_W-1:0]     words_loaded
);

  localparam int HOLD_W    = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam int HOLD_LAST = (RESET_HOLD > 0) ? RESET_HOLD - 1 : 0;

  loader_state_t     state_q, state_d;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  word_idx;
  logic [HOLD_W-1:0] hold_cnt;
  logic              ser_empty, ser_last;
  logic              accept, start_take, last_word;

  assign start_take = start && (state_q inside {IDLE, RUN, ERR});
  assign last_word  = ser_last && (words_loaded == num_q - CNT_W'(1));

  // Prefetch the next word only while another one is still owed.
  assign stream.in_ready = (state_q == LOAD) &&
                           (ser_empty || (ser_last && ((num_q - words_loaded) > CNT_W'(1))));
  assign accept = stream.in_valid && stream.in_ready;

  assign core_reset = (state_q != RUN);
  assign done       = (state_q == RUN);
  assign error      = (state_q == ERR);

  word_serializer #(
    .XLEN       (XLEN),
    .ADDR_W     (ADDR_W),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_ser (
    .clock     (clock),
    .reset     (reset),
    .load      (accept),
    .word      (stream.in_data),
    .base      (ADDR_W'(word_idx * BYTES)),
    .empty     (ser_empty),
    .last_byte (ser_last),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // NOTE: state_d is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN, ERR: begin
        if (start) begin
          if (num_words > CNT_W'(DEPTH_WORDS)) state_d = ERR;
          else if (num_words == '0)            state_d = HOLD;
          else                                 state_d = LOAD;
        end
      end
      LOAD:    if (last_word) state_d = HOLD;
      HOLD:    if (hold_cnt == HOLD_W'(HOLD_LAST)) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      num_q        <= '0;
      word_idx     <= '0;
      words_loaded <= '0;
      hold_cnt     <= '0;
    end else begin
      if (start_take) begin
        num_q        <= num_words;
        word_idx     <= '0;
        words_loaded <= '0;
      end else begin
        if (accept)   word_idx     <= word_idx + CNT_W'(1);
        if (ser_last) words_loaded <= words_loaded + CNT_W'(1);
      end
      hold_cnt <= (state_q == HOLD) ? hold_cnt + HOLD_W'(1) : '0;
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Scoreboard bench: big- and little-endian loaders share one stimulus stream.
module tb_imem_boot_loader;

  localparam int XLEN   = 32;
  localparam int DEPTH  = 256;
  localparam int RH     = 2;
  localparam int BYTES  = 4;
  localparam int CNT_W  = 9;
  localparam int ADDR_W = 10;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } wr_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_words = '0;
  logic             in_valid = 1'b0;
  logic [XLEN-1:0]  in_data = '0;

  logic [1:0]             mem_we, core_reset, done, error;
  logic [1:0][ADDR_W-1:0] mem_addr;
  logic [1:0][7:0]        mem_wdata;
  logic [1:0][CNT_W-1:0]  words_loaded;

  always #5 clock = ~clock;

  imem_boot_loader_if #(.XLEN(XLEN)) bus_be ();
  imem_boot_loader_if #(.XLEN(XLEN)) bus_le ();
  assign bus_be.in_valid = in_valid;
  assign bus_be.in_data  = in_data;
  assign bus_le.in_valid = in_valid;
  assign bus_le.in_data  = in_data;

  imem_boot_loader #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .BIG_ENDIAN(1'b1), .RESET_HOLD(RH)) dut_be (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words), .stream(bus_be),
    .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
    .core_reset(core_reset[0]), .done(done[0]), .error(error[0]), .words_loaded(words_loaded[0]));

  imem_boot_loader #(.XLEN(XLEN), .DEPTH_WORDS(DEPTH), .BIG_ENDIAN(1'b0), .RESET_HOLD(RH)) dut_le (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words), .stream(bus_le),
    .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
    .core_reset(core_reset[1]), .done(done[1]), .error(error[1]), .words_loaded(words_loaded[1]));

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  wr_t        exp_q[2][$];
  logic [7:0] img[2][DEPTH*BYTES];
  int         wr_count[2];
  int         run_len[2];
  int         last_wr_cyc[2];
  logic [1:0] we_prev = '0;

  logic [XLEN-1:0] words[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Monitor: every write must match the head of that DUT's expected queue.
  always @(negedge clock) begin : monitor
    wr_t e;
    if (!reset) begin
      for (int d = 0; d < 2; d++) begin
        if (mem_we[d]) begin
          if (exp_q[d].size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write_%s: got addr %0h data %0h expected no write",
                     d ? "le" : "be", mem_addr[d], mem_wdata[d]);
          end else begin
            e = exp_q[d].pop_front();
            check($sformatf("wr_addr_%s", d ? "le" : "be"), 32'(mem_addr[d]), 32'(e.addr));
            check($sformatf("wr_data_%s", d ? "le" : "be"), 32'(mem_wdata[d]), 32'(e.data));
          end
          img[d][mem_addr[d]] = mem_wdata[d];
          wr_count[d]++;
          run_len[d]     = we_prev[d] ? run_len[d] + 1 : 1;
          last_wr_cyc[d] = cyc;
        end
        we_prev[d] = mem_we[d];
      end
    end else begin
      we_prev = '0;
    end
  end

  // Reference: word i occupies bytes 4i..4i+3; big-endian puts the MSB first.
  task automatic push_exp(input int idx, input logic [XLEN-1:0] w);
    for (int k = 0; k < BYTES; k++) begin
      exp_q[0].push_back({ADDR_W'(idx * BYTES + k), 8'(w >> (8 * (BYTES - 1 - k)))});
      exp_q[1].push_back({ADDR_W'(idx * BYTES + k), 8'(w >> (8 * k))});
    end
  endtask

  task automatic fill_random(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  // mode 0: valid always, 1: valid pattern 1,0,0, 2: random valid.
  task automatic stream_words(input int n, input int mode, input int abort_addr, output bit aborted);
    int  idx = 0;
    int  guard = 0;
    int  phase = 0;
    logic v;
    aborted = 1'b0;
    while (idx < n && guard < 20000) begin
      @(negedge clock);
      guard++;
      if (abort_addr >= 0 && mem_we[0] && mem_addr[0] == ADDR_W'(abort_addr)) begin
        #1 reset = 1'b1;
        in_valid = 1'b0;
        aborted  = 1'b1;
        return;
      end
      case (mode)
        0:       v = 1'b1;
        1:       v = (phase % 3 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      phase++;
      in_valid = v;
      in_data  = words[idx];
      if (v && bus_be.in_ready) begin
        push_exp(idx, words[idx]);
        idx++;
      end
    end
    if (idx < n) begin
      checks++;
      failures++;
      $display("FAIL stream_timeout: got %0d words accepted expected %0d", idx, n);
    end
    if (n > 0) begin
      @(negedge clock);
      in_valid = 1'b0;
    end
  endtask

  task automatic pulse_start(input int n, output int s_cyc);
    @(negedge clock);
    start     = 1'b1;
    num_words = CNT_W'(n);
    s_cyc     = cyc;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic run_load(input int n, input int mode, output int s_cyc, output int fall_cyc);
    int guard = 0;
    bit ab;
    pulse_start(n, s_cyc);
    check("core_reset_after_start", 32'(core_reset[0]), 32'd1);
    check("done_after_start", 32'(done[0]), 32'd0);
    stream_words(n, mode, -1, ab);
    while (core_reset[0] && guard < 3000) begin
      @(negedge clock);
      guard++;
    end
    if (core_reset[0]) begin
      checks++;
      failures++;
      $display("FAIL release_timeout: got core_reset 1 expected 0 within budget");
    end
    fall_cyc = cyc;
  endtask

  task automatic end_checks(input string tag, input int n, input int b0, input int b1);
    check({tag, "_writes_be"}, 32'(wr_count[0] - b0), 32'(n * BYTES));
    check({tag, "_writes_le"}, 32'(wr_count[1] - b1), 32'(n * BYTES));
    check({tag, "_queue_be"}, 32'(exp_q[0].size()), 32'd0);
    check({tag, "_queue_le"}, 32'(exp_q[1].size()), 32'd0);
    check({tag, "_done"}, 32'(done), 32'b11);
    check({tag, "_error"}, 32'(error), 32'b00);
    check({tag, "_words_be"}, 32'(words_loaded[0]), 32'(n));
    check({tag, "_words_le"}, 32'(words_loaded[1]), 32'(n));
  endtask

  initial begin
    int s_cyc, fall_cyc, b0, b1;
    bit ab;

    #2 reset = 1'b1;
    repeat (3) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      check("rst_mem_we", 32'(mem_we[d]), 32'd0);
      check("rst_mem_addr", 32'(mem_addr[d]), 32'd0);
      check("rst_mem_wdata", 32'(mem_wdata[d]), 32'd0);
      check("rst_core_reset", 32'(core_reset[d]), 32'd1);
      check("rst_done", 32'(done[d]), 32'd0);
      check("rst_error", 32'(error[d]), 32'd0);
      check("rst_words_loaded", 32'(words_loaded[d]), 32'd0);
    end
    check("rst_in_ready", 32'({bus_le.in_ready, bus_be.in_ready}), 32'd0);
    reset = 1'b0;

    // Directed program, valid always high.
    words = '{32'h00000000, 32'h05028293, 32'h01428213, 32'h00428533, 32'h40428633};
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(5, 0, s_cyc, fall_cyc);
    end_checks("prog", 5, b0, b1);
    check("prog_no_bubble_be", 32'(run_len[0]), 32'd20);
    check("prog_no_bubble_le", 32'(run_len[1]), 32'd20);
    check("be_addr4", 32'(img[0][4]), 32'h05);
    check("be_addr7", 32'(img[0][7]), 32'h93);
    check("be_addr19", 32'(img[0][19]), 32'h33);
    check("le_addr4", 32'(img[1][4]), 32'h93);
    check("le_addr7", 32'(img[1][7]), 32'h05);
    check("le_addr16", 32'(img[1][16]), 32'h33);
    check("le_addr19", 32'(img[1][19]), 32'h40);
    check("prog_release_delay", 32'(fall_cyc - last_wr_cyc[0]), 32'(RH + 1));

    // Sparse valid.
    fill_random(3);
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(3, 1, s_cyc, fall_cyc);
    end_checks("sparse", 3, b0, b1);
    check("sparse_release_delay", 32'(fall_cyc - last_wr_cyc[0]), 32'(RH + 1));

    // Oversized request from RUN.
    b0 = wr_count[0]; b1 = wr_count[1];
    pulse_start(DEPTH + 1, s_cyc);
    check("err_error", 32'(error), 32'b11);
    check("err_core_reset", 32'(core_reset), 32'b11);
    check("err_done", 32'(done), 32'b00);
    check("err_in_ready", 32'(bus_be.in_ready), 32'd0);
    repeat (4) @(negedge clock);
    check("err_sticky", 32'(error), 32'b11);
    check("err_no_writes", 32'((wr_count[0] - b0) + (wr_count[1] - b1)), 32'd0);
    fill_random(1);
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(1, 0, s_cyc, fall_cyc);
    end_checks("after_err", 1, b0, b1);

    // Zero-length load only runs the guard interval.
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(0, 0, s_cyc, fall_cyc);
    end_checks("zero", 0, b0, b1);
    check("zero_release_delay", 32'(fall_cyc - s_cyc), 32'(RH + 1));

    // Reset on the 2nd byte of word 2 (byte address 9).
    fill_random(5);
    pulse_start(5, s_cyc);
    stream_words(5, 0, 9, ab);
    check("abort_seen", 32'(ab), 32'd1);
    #1;
    check("abort_mem_we", 32'(mem_we), 32'b00);
    check("abort_core_reset", 32'(core_reset), 32'b11);
    check("abort_words_loaded", 32'(words_loaded[0]), 32'd0);
    check("abort_done", 32'(done), 32'b00);
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clock);
    reset = 1'b0;
    fill_random(5);
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(5, 0, s_cyc, fall_cyc);
    end_checks("post_abort", 5, b0, b1);

    // Restart from RUN.
    fill_random(2);
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(2, 0, s_cyc, fall_cyc);
    end_checks("rerun", 2, b0, b1);

    // Full-capacity load.
    fill_random(DEPTH);
    b0 = wr_count[0]; b1 = wr_count[1];
    run_load(DEPTH, 0, s_cyc, fall_cyc);
    end_checks("full", DEPTH, b0, b1);
    check("full_last_be", 32'(img[0][DEPTH*BYTES-1]), 32'(words[DEPTH-1] & 32'hff));
    check("full_last_le", 32'(img[1][DEPTH*BYTES-1]), 32'(words[DEPTH-1] >> 24));

    // Random lengths and valid patterns.
    for (int it = 0; it < 6; it++) begin
      int n;
      n = $urandom_range(1, 8);
      fill_random(n);
      b0 = wr_count[0]; b1 = wr_count[1];
      run_load(n, 2, s_cyc, fall_cyc);
      end_checks("rand", n, b0, b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Synthesizable replacement for backdoor instruction-memory preloading.
- Accepts a count of instruction words, then a valid/ready stream of XLEN-bit words, and serializes each word into the byte-wide instruction RAM write port in a configurable byte order.
- Holds the core in reset until the load completes plus a programmable guard interval, then releases it.
- Sits between a host/debug stream source and the Core's instruction memory write port and reset input.

Parameters:
- XLEN, 32, instruction word width in bits; multiple of 8.
- DEPTH_WORDS, 256, instruction memory capacity in words.
- BIG_ENDIAN, 1, 1 = word bits [XLEN-1:XLEN-8] go to the lowest byte address; 0 = bits [7:0] go to the lowest byte address.
- RESET_HOLD, 2, cycles core_reset stays high after the last byte write; 0 is legal.
- (derived) BYTES = XLEN/8; CNT_W = $clog2(DEPTH_WORDS+1); ADDR_W = $clog2(DEPTH_WORDS*BYTES).

Ports:
- clock, in, 1, system clock; rising edge.
- reset, in, 1, asynchronous, active-high reset.
- start, in, 1, single-cycle pulse that begins a load; sampled in IDLE, RUN and ERR.
- num_words, in, CNT_W, number of words to load; sampled when start is accepted.
- in_valid, in, 1, stream word valid.
- in_data, in, XLEN, stream word.
- in_ready, out, 1, loader accepts in_data this cycle when in_valid is also high.
- mem_we, out, 1, byte write enable to the instruction RAM.
- mem_addr, out, ADDR_W, byte address.
- mem_wdata, out, 8, byte data.
- core_reset, out, 1, reset to the Core; active-high.
- done, out, 1, high in RUN.
- error, out, 1, high in ERR.
- words_loaded, out, CNT_W, count of words fully written in the current load.

Behaviour:
- Reset (async):
  - state = IDLE, core_reset = 1.
  - mem_we = 0, mem_addr = 0, mem_wdata = 0.
  - in_ready = 0, done = 0, error = 0, words_loaded = 0.
- States: IDLE, LOAD, HOLD, RUN, ERR.
- IDLE:
  - core_reset = 1.
  - start with num_words > DEPTH_WORDS goes to ERR.
  - start with num_words == 0 goes to HOLD.
  - Otherwise start goes to LOAD; word index and words_loaded clear to 0.
- LOAD: handshake
  - A word transfers on a cycle where in_valid && in_ready.
  - in_ready = 1 in LOAD when the serializer is empty, or when the serializer is emitting its last byte and the remaining word count is > 1.
  - in_ready is never high outside LOAD.
- LOAD: serialization
  - A word accepted in cycle t produces BYTES consecutive writes in cycles t+1 .. t+BYTES.
  - Each write has mem_we = 1 and mem_addr = word_index*BYTES + lane, with lane 0..BYTES-1.
  - BIG_ENDIAN = 1: lane k carries in_data[XLEN-1-8k -: 8].
  - BIG_ENDIAN = 0: lane k carries in_data[8k +: 8].
  - Peak throughput is one word per BYTES cycles with no bubble.
- LOAD: counting and exit
  - words_loaded increments in the cycle of each word's last byte write.
  - The cycle after the write of byte BYTES-1 of word num_words-1, the block enters HOLD.
- in_valid low mid-load: the serializer finishes the current word, then idles with mem_we = 0; there is no timeout.
- HOLD:
  - core_reset = 1; counts RESET_HOLD cycles, then goes to RUN.
  - With RESET_HOLD = 0, HOLD lasts exactly one cycle.
- RUN:
  - core_reset = 0, done = 1.
  - start re-enters the IDLE decision in the same cycle: core_reset returns to 1 the next cycle and done drops.
- ERR:
  - error = 1, core_reset = 1, no writes.
  - Left only by reset or by a valid start, which is decided exactly as in IDLE.
- start while in LOAD or HOLD is ignored.
- mem_we is low in every state except LOAD write cycles; mem_addr and mem_wdata hold their last value when mem_we = 0.
- Reset asserted mid-load aborts immediately: partially written memory is left as is, and all outputs return to their reset values.

Decomposition:
- Shared package imem_loader_pkg:
  - loader_state_t enum (IDLE, LOAD, HOLD, RUN, ERR).
  - Byte-order constants ORDER_BIG / ORDER_LITTLE.
  - Function byte_lane(word, lane, big_endian) returning an 8-bit lane.
- Sub-module word_serializer:
  - Holds one XLEN word, a lane counter and a base address.
  - Emits BYTES byte writes; exposes empty and last_byte to the top-level FSM.
  - Top level contains only the FSM, the counters and the hold timer.

Test Plan:
- Load 5 words {00000000, 05028293, 01428213, 00428533, 40428633}, BIG_ENDIAN = 1, in_valid always high:
  - 20 writes at addresses 0..19; addr 4 = 05, addr 7 = 93, addr 19 = 33.
  - No bubbles.
  - core_reset falls RESET_HOLD+1 cycles after the write to addr 19; done = 1; words_loaded = 5.
- Same words with BIG_ENDIAN = 0: addr 4 = 93, addr 7 = 05, addr 16 = 33, addr 19 = 40.
- num_words = 3 with in_valid toggling 1,0,0,1,... : exactly 12 writes, no duplicates, in_ready never high while in_valid is low for more than one word; HOLD is entered only after the 12th write.
- num_words = 257 with DEPTH_WORDS = 256: ERR next cycle, error = 1, zero writes.
  - A following start with num_words = 1 loads normally and error = 0.
- num_words = 0: no writes; core_reset falls after RESET_HOLD+1 cycles.
- Reset asserted on the 2nd byte of word 2:
  - mem_we drops asynchronously; core_reset = 1, state IDLE, words_loaded = 0.
  - A subsequent full load of 5 words succeeds.
- start in RUN: core_reset = 1 next cycle, done = 0, reload of 2 words completes.
